// File: rtl/coeff_lut_pipe_if.sv
// Request, result and host-load signals of the double-banked coefficient table.
interface coeff_lut_pipe_if #(
    parameter int SEG_BITS = 7,
    parameter int A_W      = 12,
    parameter int B_W      = 20,
    parameter int C_W      = 28,
    parameter int X2_W     = 17,
    parameter int WD_W     = 28
);
    logic                in_valid;
    logic                in_ready;
    logic [SEG_BITS-1:0] in_x1;
    logic [X2_W-1:0]     in_x2;
    logic                out_valid;
    logic                out_ready;
    logic [A_W-1:0]      out_a;
    logic [B_W-1:0]      out_b;
    logic [C_W-1:0]      out_c;
    logic [X2_W-1:0]     out_x2;
    logic                out_bank;
    logic                wr_en;
    logic [1:0]          wr_sel;
    logic [SEG_BITS-1:0] wr_addr;
    logic [WD_W-1:0]     wr_data;
    logic                swap_req;
    logic                active_bank;

    modport master (
        output in_valid, in_x1, in_x2, out_ready,
        output wr_en, wr_sel, wr_addr, wr_data, swap_req,
        input  in_ready, out_valid, out_a, out_b, out_c, out_x2, out_bank, active_bank
    );

    modport slave (
        input  in_valid, in_x1, in_x2, out_ready,
        input  wr_en, wr_sel, wr_addr, wr_data, swap_req,
        output in_ready, out_valid, out_a, out_b, out_c, out_x2, out_bank, active_bank
    );
endinterface

// File: rtl/coeff_lut_pipe.sv
// Two-stage, double-banked a/b/c coefficient lookup with x2 sideband.
// Reads use the active bank sampled at acceptance; host writes always hit the shadow bank.
module coeff_lut_pipe #(
    parameter int SEG_BITS = 7,
    parameter int A_W      = 12,
    parameter int B_W      = 20,
    parameter int C_W      = 28,
    parameter int X2_W     = 17,
    parameter int WD_W     = 28
) (
    input logic             clk,
    input logic             rst,
    coeff_lut_pipe_if.slave bus
);
    localparam int DEPTH = 1 << SEG_BITS;

    logic [A_W-1:0]  mem_a_q [2][DEPTH];
    logic [B_W-1:0]  mem_b_q [2][DEPTH];
    logic [C_W-1:0]  mem_c_q [2][DEPTH];

    logic            active_bank_q, active_bank_d;
    logic            advance;

    logic            s1_valid_q;
    logic [A_W-1:0]  s1_a_q;
    logic [B_W-1:0]  s1_b_q;
    logic [C_W-1:0]  s1_c_q;
    logic [X2_W-1:0] s1_x2_q;
    logic            s1_bank_q;

    logic            out_valid_q;
    logic [A_W-1:0]  out_a_q;
    logic [B_W-1:0]  out_b_q;
    logic [C_W-1:0]  out_c_q;
    logic [X2_W-1:0] out_x2_q;
    logic            out_bank_q;

    // Pipeline advance and next active bank.
    always_comb begin
        advance       = !out_valid_q || bus.out_ready;
        active_bank_d = active_bank_q ^ bus.swap_req;
    end

    assign bus.in_ready    = advance;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = out_a_q;
    assign bus.out_b       = out_b_q;
    assign bus.out_c       = out_c_q;
    assign bus.out_x2      = out_x2_q;
    assign bus.out_bank    = out_bank_q;
    assign bus.active_bank = active_bank_q;

    // Host writes into the shadow bank; tables are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            case (bus.wr_sel)
                2'd0:    mem_a_q[!active_bank_q][bus.wr_addr] <= bus.wr_data[A_W-1:0];
                2'd1:    mem_b_q[!active_bank_q][bus.wr_addr] <= bus.wr_data[B_W-1:0];
                2'd2:    mem_c_q[!active_bank_q][bus.wr_addr] <= bus.wr_data[C_W-1:0];
                default: ;
            endcase
        end
    end

    // S1 data: registered table read from the bank active at acceptance.
    always_ff @(posedge clk) begin
        if (advance && bus.in_valid) begin
            s1_a_q    <= mem_a_q[active_bank_q][bus.in_x1];
            s1_b_q    <= mem_b_q[active_bank_q][bus.in_x1];
            s1_c_q    <= mem_c_q[active_bank_q][bus.in_x1];
            s1_x2_q   <= bus.in_x2;
            s1_bank_q <= active_bank_q;
        end
    end

    // Bank state, stage valids and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_bank_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_c_q       <= '0;
            out_x2_q      <= '0;
            out_bank_q    <= 1'b0;
        end else begin
            active_bank_q <= active_bank_d;
            if (advance) begin
                s1_valid_q  <= bus.in_valid;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_a_q    <= s1_a_q;
                    out_b_q    <= s1_b_q;
                    out_c_q    <= s1_c_q;
                    out_x2_q   <= s1_x2_q;
                    out_bank_q <= s1_bank_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_coeff_lut_pipe.sv
// Scoreboard bench for coeff_lut_pipe: a bench-side table model predicts each accepted
// request; results are popped and compared as the DUT delivers them.
module tb_coeff_lut_pipe;
    localparam int SEG_BITS = 7;
    localparam int A_W      = 12;
    localparam int B_W      = 20;
    localparam int C_W      = 28;
    localparam int X2_W     = 17;
    localparam int WD_W     = 28;
    localparam int DEPTH    = 1 << SEG_BITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coeff_lut_pipe_if #(.SEG_BITS(SEG_BITS), .A_W(A_W), .B_W(B_W), .C_W(C_W),
                        .X2_W(X2_W), .WD_W(WD_W)) bus ();

    coeff_lut_pipe #(.SEG_BITS(SEG_BITS), .A_W(A_W), .B_W(B_W), .C_W(C_W),
                     .X2_W(X2_W), .WD_W(WD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [A_W-1:0]  a;
        logic [B_W-1:0]  b;
        logic [C_W-1:0]  c;
        logic [X2_W-1:0] x2;
        logic            bank;
    } res_t;

    res_t           sb[$];
    logic [A_W-1:0] ma [2][DEPTH];
    logic [B_W-1:0] mb [2][DEPTH];
    logic [C_W-1:0] mc [2][DEPTH];
    logic           mbank = 1'b0;
    int             checks = 0;
    int             errors = 0;
    int             pops = 0;
    res_t           prev_out;
    bit             prev_stall = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor and model, sampled mid-cycle: everything seen here applies at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mbank      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check_val("active_bank", bus.active_bank, mbank);
            check_val("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (prev_stall) begin
                check_val("hold_valid", bus.out_valid, 1'b1);
                check_val("hold_data", {bus.out_a, bus.out_b, bus.out_c, bus.out_x2, bus.out_bank},
                          prev_out);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 1'b1, 1'b0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    pops++;
                    check_val("out_a", bus.out_a, e.a);
                    check_val("out_b", bus.out_b, e.b);
                    check_val("out_c", bus.out_c, e.c);
                    check_val("out_x2", bus.out_x2, e.x2);
                    check_val("out_bank", bus.out_bank, e.bank);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{ma[mbank][bus.in_x1], mb[mbank][bus.in_x1], mc[mbank][bus.in_x1],
                               bus.in_x2, mbank});
            if (bus.wr_en) begin
                case (bus.wr_sel)
                    2'd0: ma[!mbank][bus.wr_addr] = bus.wr_data[A_W-1:0];
                    2'd1: mb[!mbank][bus.wr_addr] = bus.wr_data[B_W-1:0];
                    2'd2: mc[!mbank][bus.wr_addr] = bus.wr_data[C_W-1:0];
                    default: ;
                endcase
            end
            if (bus.swap_req) mbank = !mbank;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_a, bus.out_b, bus.out_c, bus.out_x2, bus.out_bank};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_x1     = '0;
        bus.in_x2     = '0;
        bus.out_ready = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_sel    = 2'd3;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.swap_req  = 1'b0;
    endtask

    task automatic host_write(input logic [1:0] sel, input int addr, input logic [WD_W-1:0] data,
                              input logic swap);
        bus.wr_en    = 1'b1;
        bus.wr_sel   = sel;
        bus.wr_addr  = SEG_BITS'(addr);
        bus.wr_data  = data;
        bus.swap_req = swap;
        tick();
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    task automatic swap_banks();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    // Issue requests x1 = first, first+step, ... with optional out_ready stall window.
    task automatic stream(input int n, input int first, input int step,
                          input int stall_at, input int stall_len);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 1000) begin
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.in_valid  = 1'b1;
            bus.in_x1     = SEG_BITS'(first + sent * step);
            bus.in_x2     = X2_W'(32'h1000 + sent * 7);
            #1;
            if (bus.in_ready) sent++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_val("stream_sent", sent, n);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        check_val("drain", sb.size(), 0);
    endtask

    initial begin
        int p0;
        logic [C_W-1:0] old_c3;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_active", bus.active_bank, 1'b0);
        check_val("rst_out_a", bus.out_a, '0);

        // Fill both banks through the shadow port.
        for (int bank = 0; bank < 2; bank++) begin
            for (int i = 0; i < DEPTH; i++) begin
                host_write(2'd0, i, WD_W'($urandom), 1'b0);
                host_write(2'd1, i, WD_W'($urandom), 1'b0);
                host_write(2'd2, i, WD_W'($urandom), 1'b0);
            end
            swap_banks();
        end

        // Directed load of bank 0 entry 5 and latency check.
        swap_banks();
        host_write(2'd0, 5, 28'h00007FF, 1'b0);
        host_write(2'd1, 5, 28'h0080001, 1'b0);
        host_write(2'd2, 5, 28'h1234567, 1'b0);
        swap_banks();
        bus.in_valid = 1'b1;
        bus.in_x1    = 7'd5;
        bus.in_x2    = 17'h1ABCD;
        tick();
        bus.in_valid = 1'b0;
        check_val("lat1_valid", bus.out_valid, 1'b0);
        tick();
        check_val("lat2_valid", bus.out_valid, 1'b1);
        check_val("load_a", bus.out_a, 12'h7FF);
        check_val("load_b", bus.out_b, 20'h80001);
        check_val("load_c", bus.out_c, 28'h1234567);
        check_val("load_x2", bus.out_x2, 17'h1ABCD);
        check_val("load_bank", bus.out_bank, 1'b0);
        drain();

        // Back-to-back full sweep: 128 results in 128 cycles.
        p0 = pops;
        stream(DEPTH, 0, 1, 1000, 0);
        tick();
        tick();
        check_val("b2b_count", pops - p0, DEPTH);
        drain();

        // Backpressure mid-stream.
        p0 = pops;
        stream(30, 1, 3, 10, 5);
        drain();
        check_val("bp_count", pops - p0, 30);

        // Reset mid-stream with bank 1 active.
        swap_banks();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_x1 = SEG_BITS'(i + 20);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("midrst_out_valid", bus.out_valid, 1'b0);
        check_val("midrst_active", bus.active_bank, 1'b0);
        tick();
        check_val("midrst_bubble", bus.out_valid, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x1    = 7'd5;
        bus.in_x2    = 17'h00042;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_val("keep_a", bus.out_a, 12'h7FF);
        check_val("keep_c", bus.out_c, 28'h1234567);
        drain();

        // Swap in the acceptance cycle: old bank for that request, new bank after.
        old_c3 = mc[0][3];
        host_write(2'd2, 3, 28'h5, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_x1    = 7'd3;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check_val("swap_old_c", bus.out_c, old_c3);
        check_val("swap_old_bank", bus.out_bank, 1'b0);
        tick();
        check_val("swap_new_c", bus.out_c, 28'h5);
        check_val("swap_new_bank", bus.out_bank, 1'b1);
        drain();

        // Write colliding with swap lands in the bank that becomes active.
        host_write(2'd0, 9, 28'h3, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_x1    = 7'd9;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_val("coll_a", bus.out_a, 12'h003);
        check_val("coll_bank", bus.out_bank, 1'b0);
        drain();

        // wr_sel=3 writes must not change any table.
        for (int i = 0; i < 20; i++)
            host_write(2'd3, int'($urandom_range(0, DEPTH - 1)), WD_W'($urandom), 1'b0);
        stream(DEPTH, 0, 1, 1000, 0);
        swap_banks();
        stream(DEPTH, 0, 1, 1000, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
